// File: rtl/lsync_mag_sq_win.sv
`default_nettype none
// ============================================================================
//  Module      : lsync_mag_sq_win
//  Description : Long-sync magnitude-squared stage with moving-window energy.
//                Two-stage |x|^2 = I^2 + Q^2 pipeline followed by a running
//                sum over the last WIN_LEN magnitudes held in a circular
//                buffer. Optional peak tracker enabled by MAG_SQ_PEAK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsync_mag_sq_win #(
    parameter  int IN_W    = 7,
    parameter  int WIN_LEN = 16,
    localparam int MAG_W   = 2 * IN_W,
    localparam int SUM_W   = MAG_W + $clog2(WIN_LEN)
) (
    input  logic                    CLK,
    input  logic                    a_RST_n,
    input  logic                    clear,
    input  logic signed [IN_W-1:0]  I_in,
    input  logic signed [IN_W-1:0]  Q_in,
    input  logic                    in_valid,
    output logic [MAG_W-1:0]        mag_out,
    output logic                    mag_valid,
    output logic [SUM_W-1:0]        win_sum,
    output logic                    win_valid,
    output logic                    win_full
`ifdef MAG_SQ_PEAK_EN
    ,
    output logic [SUM_W-1:0]        peak_sum,
    output logic [15:0]             peak_idx
`endif
);

    // ------------------------------------------------------------------
    // Local sizing
    // ------------------------------------------------------------------
    localparam int PTR_W  = $clog2(WIN_LEN);
    localparam int FILL_W = $clog2(WIN_LEN + 1);
    localparam int SQ_W   = MAG_W - 1;

    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(WIN_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIN_LEN);
    localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(WIN_LEN - 1);

    // ------------------------------------------------------------------
    // Stage 1 : squares
    // ------------------------------------------------------------------
    logic signed [SQ_W-1:0] i_ext;
    logic signed [SQ_W-1:0] q_ext;
    logic [SQ_W-1:0]        sq_i_d, sq_i_q;
    logic [SQ_W-1:0]        sq_q_d, sq_q_q;
    logic                   v1_d, v1_q;

    // ------------------------------------------------------------------
    // Stage 2 : magnitude
    // ------------------------------------------------------------------
    logic [MAG_W-1:0]       mag_d, mag_q;
    logic                   mag_valid_d, mag_valid_q;

    // ------------------------------------------------------------------
    // Window stage
    // ------------------------------------------------------------------
    logic [MAG_W-1:0]       win_buf [0:WIN_LEN-1];
    logic [MAG_W-1:0]       old_mag;
    logic [SUM_W-1:0]       win_sum_d, win_sum_q;
    logic                   win_valid_d, win_valid_q;
    logic                   win_full_d, win_full_q;
    logic [PTR_W-1:0]       wr_ptr_d, wr_ptr_q;
    logic [FILL_W-1:0]      fill_d, fill_q;
    logic                   win_step;

`ifdef MAG_SQ_PEAK_EN
    logic [SUM_W-1:0]       peak_sum_d, peak_sum_q;
    logic [15:0]            peak_idx_d, peak_idx_q;
    logic [15:0]            sample_cnt_d, sample_cnt_q;
`endif

    // Squares: the low SQ_W bits of the signed product are the exact
    // unsigned square, since the largest square (2^(IN_W-1))^2 < 2^SQ_W.
    always_comb begin
        i_ext  = SQ_W'(I_in);
        q_ext  = SQ_W'(Q_in);
        sq_i_d = sq_i_q;
        sq_q_d = sq_q_q;
        v1_d   = in_valid & ~clear;
        if (in_valid && !clear) begin
            sq_i_d = $unsigned(i_ext * i_ext);
            sq_q_d = $unsigned(q_ext * q_ext);
        end
    end

    // Magnitude sum: output holds its last value between strobes.
    always_comb begin
        mag_d       = mag_q;
        mag_valid_d = v1_q & ~clear;
        if (v1_q && !clear) begin
            mag_d = {1'b0, sq_i_q} + {1'b0, sq_q_q};
        end
    end

    // Oldest sample only contributes once the buffer is known to be full,
    // so stale contents left behind by a reset/clear are never read.
    assign old_mag  = win_full_q ? win_buf[wr_ptr_q] : '0;
    assign win_step = mag_valid_q & ~clear;

    // Window update: add newest magnitude, retire the oldest one.
    always_comb begin
        win_sum_d   = win_sum_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        win_full_d  = win_full_q;
        win_valid_d = 1'b0;
        if (clear) begin
            win_sum_d  = '0;
            wr_ptr_d   = '0;
            fill_d     = '0;
            win_full_d = 1'b0;
        end else if (mag_valid_q) begin
            win_sum_d   = win_sum_q + SUM_W'(mag_q) - SUM_W'(old_mag);
            wr_ptr_d    = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            fill_d      = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
            win_full_d  = win_full_q | (fill_q == FILL_PRE);
            win_valid_d = 1'b1;
        end
    end

`ifdef MAG_SQ_PEAK_EN
    // Peak tracker: sample_cnt counts samples reaching the window, which is
    // the 1-based index of the sample that closes the current window.
    // Strict compare keeps the earlier peak on ties.
    always_comb begin
        peak_sum_d   = peak_sum_q;
        peak_idx_d   = peak_idx_q;
        sample_cnt_d = sample_cnt_q;
        if (clear) begin
            peak_sum_d   = '0;
            peak_idx_d   = '0;
            sample_cnt_d = '0;
        end else if (mag_valid_q) begin
            sample_cnt_d = sample_cnt_q + 16'd1;
            if (win_full_d && (win_sum_d > peak_sum_q)) begin
                peak_sum_d = win_sum_d;
                peak_idx_d = sample_cnt_d;
            end
        end
    end
`endif

    // Pipeline, window and control state registers.
    always_ff @(posedge CLK or negedge a_RST_n) begin
        if (!a_RST_n) begin
            sq_i_q       <= '0;
            sq_q_q       <= '0;
            v1_q         <= 1'b0;
            mag_q        <= '0;
            mag_valid_q  <= 1'b0;
            win_sum_q    <= '0;
            win_valid_q  <= 1'b0;
            win_full_q   <= 1'b0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
`ifdef MAG_SQ_PEAK_EN
            peak_sum_q   <= '0;
            peak_idx_q   <= '0;
            sample_cnt_q <= '0;
`endif
        end else begin
            sq_i_q       <= sq_i_d;
            sq_q_q       <= sq_q_d;
            v1_q         <= v1_d;
            mag_q        <= mag_d;
            mag_valid_q  <= mag_valid_d;
            win_sum_q    <= win_sum_d;
            win_valid_q  <= win_valid_d;
            win_full_q   <= win_full_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
`ifdef MAG_SQ_PEAK_EN
            peak_sum_q   <= peak_sum_d;
            peak_idx_q   <= peak_idx_d;
            sample_cnt_q <= sample_cnt_d;
`endif
        end
    end

    // Circular buffer storage; contents are don't-care until written.
    always_ff @(posedge CLK) begin
        if (win_step) begin
            win_buf[wr_ptr_q] <= mag_q;
        end
    end

    assign mag_out   = mag_q;
    assign mag_valid = mag_valid_q;
    assign win_sum   = win_sum_q;
    assign win_valid = win_valid_q;
    assign win_full  = win_full_q;
`ifdef MAG_SQ_PEAK_EN
    assign peak_sum  = peak_sum_q;
    assign peak_idx  = peak_idx_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsync_mag_sq_win.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsync_mag_sq_win
//  Description : Scoreboard bench for lsync_mag_sq_win (IN_W=7, WIN_LEN=4).
//                Directed vectors push hand-computed expectations; a monitor
//                pops and compares on every mag_valid / win_valid strobe,
//                including the strobe latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsync_mag_sq_win;

    localparam int IN_W    = 7;
    localparam int WIN_LEN = 4;
    localparam int MAG_W   = 2 * IN_W;
    localparam int SUM_W   = MAG_W + $clog2(WIN_LEN);

    logic                   clk = 1'b0;
    logic                   a_RST_n;
    logic                   clear;
    logic signed [IN_W-1:0] I_in;
    logic signed [IN_W-1:0] Q_in;
    logic                   in_valid;
    logic [MAG_W-1:0]       mag_out;
    logic                   mag_valid;
    logic [SUM_W-1:0]       win_sum;
    logic                   win_valid;
    logic                   win_full;
`ifdef MAG_SQ_PEAK_EN
    logic [SUM_W-1:0]       peak_sum;
    logic [15:0]            peak_idx;
`endif

    lsync_mag_sq_win #(.IN_W(IN_W), .WIN_LEN(WIN_LEN)) dut (
        .CLK       (clk),
        .a_RST_n   (a_RST_n),
        .clear     (clear),
        .I_in      (I_in),
        .Q_in      (Q_in),
        .in_valid  (in_valid),
        .mag_out   (mag_out),
        .mag_valid (mag_valid),
        .win_sum   (win_sum),
        .win_valid (win_valid),
        .win_full  (win_full)
`ifdef MAG_SQ_PEAK_EN
        ,
        .peak_sum  (peak_sum),
        .peak_idx  (peak_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        bit full;
        int cyc;
    } exp_t;

    exp_t mag_exp[$];
    exp_t win_exp[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // Monitor: pops one expectation per output strobe
    always @(negedge clk) begin
        exp_t e;
        if (mag_valid) begin
            if (mag_exp.size() == 0) begin
                check("mag_unexpected_strobe", 1, 0);
            end else begin
                e = mag_exp.pop_front();
                check("mag_out", mag_out, e.val);
                check("mag_latency", cyc, e.cyc + 2);
            end
        end
        if (win_valid) begin
            if (win_exp.size() == 0) begin
                check("win_unexpected_strobe", 1, 0);
            end else begin
                e = win_exp.pop_front();
                check("win_sum", win_sum, e.val);
                check("win_full", win_full, e.full);
                check("win_latency", cyc, e.cyc + 3);
            end
        end
    end

    // Drive one sample for one cycle and queue what it should produce
    task automatic send(input int i, input int q, input int em, input int es,
                        input bit ef, input bit pm, input bit pw, input bit clr);
        exp_t e;
        @(posedge clk);
        #1;
        I_in     = IN_W'(i);
        Q_in     = IN_W'(q);
        in_valid = 1'b1;
        clear    = clr;
        if (pm) begin
            e.val = em; e.full = 1'b0; e.cyc = cyc;
            mag_exp.push_back(e);
        end
        if (pw) begin
            e.val = es; e.full = ef; e.cyc = cyc;
            win_exp.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            clear    = 1'b0;
        end
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
    endtask

    // Bounded wait for all queued expectations to be consumed
    task automatic drain();
        for (int k = 0; k < 20 && (mag_exp.size() != 0 || win_exp.size() != 0); k++)
            @(posedge clk);
        if (mag_exp.size() != 0) check("mag_missing_strobes", 0, mag_exp.size());
        if (win_exp.size() != 0) check("win_missing_strobes", 0, win_exp.size());
        mag_exp.delete();
        win_exp.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mag_out"},   mag_out,   0);
        check({tag, "_mag_valid"}, mag_valid, 0);
        check({tag, "_win_sum"},   win_sum,   0);
        check({tag, "_win_valid"}, win_valid, 0);
        check({tag, "_win_full"},  win_full,  0);
    endtask

    initial begin
        int gaps [5] = '{0, 1, 2, 3, 0};
        a_RST_n  = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        I_in     = '0;
        Q_in     = '0;

        // Reset held with in_valid toggling: everything stays at zero
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            I_in     = 7'sd3;
            Q_in     = 7'sd4;
            @(negedge clk);
            if (k == 3) check_all_zero("reset");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_RST_n  = 1'b1;

        // First sample after reset, then extremes in the same window
        send(  3,   4,   25,    25, 1'b0, 1'b1, 1'b1, 1'b0);
        send(-64, -64, 8192,  8217, 1'b0, 1'b1, 1'b1, 1'b0);
        send(-64,  63, 8065, 16282, 1'b0, 1'b1, 1'b1, 1'b0);
        send(  0,   0,    0, 16282, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1);
        drain();

        // Fill with ramp and idle gaps: 1,5,14,30,54
        do_clear();
        send(1, 0,  1,  1, 1'b0, 1'b1, 1'b1, 1'b0); idle(gaps[0]);
        send(2, 0,  4,  5, 1'b0, 1'b1, 1'b1, 1'b0); idle(gaps[1]);
        send(3, 0,  9, 14, 1'b0, 1'b1, 1'b1, 1'b0); idle(gaps[2]);
        send(4, 0, 16, 30, 1'b1, 1'b1, 1'b1, 1'b0); idle(gaps[3]);
        send(5, 0, 25, 54, 1'b1, 1'b1, 1'b1, 1'b0); idle(1 + gaps[4]);
        drain();

        // Steady state back-to-back
        do_clear();
        for (int k = 1; k <= 6; k++)
            send(3, 4, 25, 25 * ((k < 4) ? k : 4), (k >= 4), 1'b1, 1'b1, 1'b0);
        idle(1);
        drain();

        // Clear in the cycle after the 2nd sample of a burst, held over the
        // rest of the burst. Sample 1 has already reached the magnitude
        // register when clear lands, so only its mag strobe is seen.
        send(3, 4, 25, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        send(3, 4,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(3, 4,  0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(3, 4,  0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        send(1, 1, 2, 2, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1);
        drain();

        // Asynchronous reset mid-burst: outputs drop before any clock edge
        send(3, 4, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(3, 4, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        a_RST_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        check_all_zero("async_reset");
`ifdef MAG_SQ_PEAK_EN
        check("async_reset_peak_sum", peak_sum, 0);
        check("async_reset_peak_idx", peak_idx, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        a_RST_n = 1'b1;
        for (int k = 1; k <= 4; k++)
            send(2, 2, 8, 8 * k, (k == 4), 1'b1, 1'b1, 1'b0);
        idle(2);
        drain();
`ifdef MAG_SQ_PEAK_EN
        check("peak_sum", peak_sum, 32);
        check("peak_idx", peak_idx, 4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
